// File: rtl/jtframe_6801_periph.sv
// 6801/63701 on-chip peripherals: I/O ports, free-running timer, output compare, input capture, TCSR.
// Optional macro JTFRAME_6801_OCPIN_EN drives the compare level onto P2 bit 1.
module jtframe_6801_periph #(
    parameter int          PORTN     = 4,
    parameter logic [15:0] FRC_WRVAL = 16'hFFF8
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    input  logic               cs,
    input  logic               wrn,
    input  logic [4:0]         addr,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    input  logic [8*PORTN-1:0] port_in,
    output logic [8*PORTN-1:0] port_out,
    output logic [8*PORTN-1:0] port_dir,
    output logic               irq_icf,
    output logic               irq_ocf,
    output logic               irq_tof
);
    localparam bit HAS_IC = PORTN >= 2;

    logic [7:0]  ddr [4];
    logic [7:0]  dat [4];
    logic [7:0]  pin [4];
    logic [15:0] frc, ocr, icr, frc_nx;
    logic [7:0]  lowbuf;
    logic        icf, ocf, tof, eici, eoci, etoi, iedg, olvl;
    logic        arm_icf, arm_ocf, arm_tof;
    logic        ic_prev, cap_pin;
    logic        wr, rd, frc_wrap, ocr_wr, oc_match, ic_edge;
    logic        icf_clr, ocf_clr, tof_clr, tcsr_rd;
    logic [1:0]  pidx;
    logic        port_ok;

    assign wr      = cen & cs & ~wrn;
    assign rd      = cen & cs & wrn;
    // Port map interleaves DDR/DAT pairs: index = {addr[2], addr[0]}, addr[1] selects data
    assign pidx    = {addr[2], addr[0]};
    assign port_ok = (addr[4:3] == 2'b00) && (int'(pidx) < PORTN);

    for (genvar g = 0; g < 4; g++) begin : g_port
        if (g < PORTN) begin : g_on
            assign pin[g]             = port_in[8*g +: 8];
            assign port_out[8*g +: 8] = dat[g];
            assign port_dir[8*g +: 8] = ddr[g];
        end else begin : g_off
            assign pin[g] = 8'hFF;
        end
    end

    if (HAS_IC) begin : g_cap
        assign cap_pin = port_in[8];
    end else begin : g_nocap
        assign cap_pin = 1'b0;
    end

    always_comb begin
        frc_nx   = frc + 16'd1;
        frc_wrap = (frc == 16'hFFFF);
        if (wr && addr == 5'h09) begin
            frc_nx   = FRC_WRVAL;
            frc_wrap = 1'b0;
        end
    end

    assign ocr_wr   = wr && (addr == 5'h0B || addr == 5'h0C);
    assign oc_match = cen && !ocr_wr && (frc_nx == ocr);
    assign ic_edge  = HAS_IC && cen && (iedg ? (cap_pin && !ic_prev) : (!cap_pin && ic_prev));
    assign tcsr_rd  = rd && addr == 5'h08;
    assign icf_clr  = rd && addr == 5'h0D && arm_icf;
    assign ocf_clr  = ocr_wr && arm_ocf;
    assign tof_clr  = rd && addr == 5'h09 && arm_tof;

    assign irq_icf = icf & eici;
    assign irq_ocf = ocf & eoci;
    assign irq_tof = tof & etoi;

    always_comb begin
        dout = 8'hFF;
        if (port_ok) begin
            dout = addr[1] ? ((dat[pidx] & ddr[pidx]) | (pin[pidx] & ~ddr[pidx])) : ddr[pidx];
        end else begin
            case (addr)
                5'h08:   dout = {icf, ocf, tof, eici, eoci, etoi, iedg, olvl};
                5'h09:   dout = frc[15:8];
                5'h0A:   dout = lowbuf;
                5'h0B:   dout = ocr[15:8];
                5'h0C:   dout = ocr[7:0];
                5'h0D:   dout = icr[15:8];
                5'h0E:   dout = icr[7:0];
                default: dout = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                ddr[i] <= 8'h00;
                dat[i] <= 8'h00;
            end
            frc     <= 16'h0000;
            ocr     <= 16'hFFFF;
            icr     <= 16'h0000;
            lowbuf  <= 8'h00;
            {icf, ocf, tof, eici, eoci, etoi, iedg, olvl} <= 8'h00;
            arm_icf <= 1'b0;
            arm_ocf <= 1'b0;
            arm_tof <= 1'b0;
            ic_prev <= 1'b0;
        end else if (cen) begin
            frc     <= frc_nx;
            ic_prev <= cap_pin;
            if (ic_edge) icr <= frc;
            if (rd && addr == 5'h09) lowbuf <= frc[7:0];
            if (wr && addr == 5'h08) {eici, eoci, etoi, iedg, olvl} <= din[4:0];
            if (wr && addr == 5'h0B) ocr[15:8] <= din;
            if (wr && addr == 5'h0C) ocr[7:0]  <= din;
`ifdef JTFRAME_6801_OCPIN_EN
            if (oc_match && HAS_IC) dat[1][1] <= olvl;
`endif
            // CPU port writes come last so they override the compare pin update
            if (wr && port_ok) begin
                if (addr[1]) dat[pidx] <= din;
                else         ddr[pidx] <= din;
            end

            // Set beats clear; a clear always drops the arm bit
            if (ic_edge)       icf <= 1'b1;
            else if (icf_clr)  icf <= 1'b0;
            if (icf_clr)       arm_icf <= 1'b0;
            else if (tcsr_rd && icf) arm_icf <= 1'b1;

            if (oc_match)      ocf <= 1'b1;
            else if (ocf_clr)  ocf <= 1'b0;
            if (ocf_clr)       arm_ocf <= 1'b0;
            else if (tcsr_rd && ocf) arm_ocf <= 1'b1;

            if (frc_wrap)      tof <= 1'b1;
            else if (tof_clr)  tof <= 1'b0;
            if (tof_clr)       arm_tof <= 1'b0;
            else if (tcsr_rd && tof) arm_tof <= 1'b1;
        end
    end
endmodule

// File: tb/tb_jtframe_6801_periph.sv
// Bench for jtframe_6801_periph: register table plus timer/capture/compare sequences.
module tb_jtframe_6801_periph;
    localparam int PORTN = 4;

    logic        clk = 1'b0;
    logic        rst, cen, cs, wrn;
    logic [4:0]  addr;
    logic [7:0]  din, dout;
    logic [31:0] port_in, port_out, port_dir;
    logic        irq_icf, irq_ocf, irq_tof;

    int n_pass = 0;
    int n_chk  = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic       wr;
        logic [4:0] a;
        logic [7:0] d;   // write data, or expected read data
    } vec_t;

    jtframe_6801_periph #(.PORTN(PORTN), .FRC_WRVAL(16'hFFF8)) dut (
        .clk(clk), .rst(rst), .cen(cen), .cs(cs), .wrn(wrn), .addr(addr), .din(din),
        .dout(dout), .port_in(port_in), .port_out(port_out), .port_dir(port_dir),
        .irq_icf(irq_icf), .irq_ocf(irq_ocf), .irq_tof(irq_tof)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        cs  = 1'b0;
        wrn = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [7:0] d);
        cs = 1'b1; wrn = 1'b0; addr = a; din = d;
        tick();
        cs = 1'b0; wrn = 1'b1;
    endtask

    task automatic rd_reg(input string name, input logic [4:0] a, input logic [7:0] e);
        cs = 1'b1; wrn = 1'b1; addr = a;
        exp_q.push_back(e);
        #2;
        check(name, 32'(dout), 32'(exp_q.pop_front()));
        tick();
        cs = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vec_t tbl[16];
        tbl[0]  = '{1'b0, 5'h08, 8'h00};
        tbl[1]  = '{1'b0, 5'h0B, 8'hFF};
        tbl[2]  = '{1'b0, 5'h0C, 8'hFF};
        tbl[3]  = '{1'b0, 5'h0D, 8'h00};
        tbl[4]  = '{1'b0, 5'h0E, 8'h00};
        tbl[5]  = '{1'b0, 5'h0F, 8'hFF};
        tbl[6]  = '{1'b0, 5'h1F, 8'hFF};
        tbl[7]  = '{1'b0, 5'h00, 8'h00};
        tbl[8]  = '{1'b1, 5'h00, 8'h0F};
        tbl[9]  = '{1'b1, 5'h02, 8'hA5};
        tbl[10] = '{1'b0, 5'h02, 8'h35};
        tbl[11] = '{1'b0, 5'h00, 8'h0F};
        tbl[12] = '{1'b1, 5'h05, 8'hC3};
        tbl[13] = '{1'b1, 5'h07, 8'h81};
        tbl[14] = '{1'b0, 5'h07, 8'hA5};
        tbl[15] = '{1'b1, 5'h0F, 8'h12};

        rst = 1'b1; cen = 1'b1; cs = 1'b0; wrn = 1'b1; addr = '0; din = '0;
        port_in = 32'h66_00_F0_3C;
        tick();
        do_reset();

        // Reset state and port behaviour
        check("rst_port_out", port_out, 32'h0);
        check("rst_port_dir", port_dir, 32'h0);
        check("rst_irq", 32'({irq_icf, irq_ocf, irq_tof}), 32'h0);
        rd_reg("rst_frch", 5'h09, 8'h00);
        rd_reg("rst_frcl", 5'h0A, 8'h00);
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].wr) wr_reg(tbl[i].a, tbl[i].d);
            else           rd_reg($sformatf("tbl%0d_a%0h", i, tbl[i].a), tbl[i].a, tbl[i].d);
        end
        rd_reg("unmapped_after_wr", 5'h0F, 8'hFF);
        check("p1_out", 32'(port_out[7:0]), 32'hA5);
        check("p1_dir", 32'(port_dir[7:0]), 32'h0F);
        check("p4_out", 32'(port_out[31:24]), 32'h81);
        check("p4_dir", 32'(port_dir[31:24]), 32'hC3);
        cen = 1'b0;
        wr_reg(5'h00, 8'hFF);
        cen = 1'b1;
        check("cen_gate_wr", 32'(port_dir[7:0]), 32'h0F);

        // FRC load, wrap, TOF arm/clear, low-byte buffer
        do_reset();
        wr_reg(5'h08, 8'h04);
        wr_reg(5'h09, 8'h00);
        idle(7);
        check("tof_before_wrap", 32'(irq_tof), 32'h0);
        idle(1);
        check("tof_at_wrap", 32'(irq_tof), 32'h1);
        rd_reg("frch_wrap", 5'h09, 8'h00);
        rd_reg("frcl_wrap", 5'h0A, 8'h00);
        check("tof_unarmed_read", 32'(irq_tof), 32'h1);
        rd_reg("tcsr_tof", 5'h08, 8'h64);
        rd_reg("frch_clr", 5'h09, 8'h00);
        check("tof_cleared", 32'(irq_tof), 32'h0);
        rd_reg("tcsr_after_tof", 5'h08, 8'h44);
        rd_reg("frcl_buf", 5'h0A, 8'h03);
        wr_reg(5'h0A, 8'h55);
        rd_reg("frch_after_a", 5'h09, 8'h00);
        rd_reg("frcl_after_a", 5'h0A, 8'h07);

        // Output compare at FRC=0x0010
        do_reset();
        wr_reg(5'h08, 8'h08);
        wr_reg(5'h0B, 8'h00);
        wr_reg(5'h0C, 8'h10);
        idle(12);
        check("ocf_before", 32'(irq_ocf), 32'h0);
        idle(1);
        check("ocf_match", 32'(irq_ocf), 32'h1);
        wr_reg(5'h0C, 8'h10);
        check("ocf_unarmed_wr", 32'(irq_ocf), 32'h1);
        rd_reg("tcsr_ocf", 5'h08, 8'h48);
        wr_reg(5'h0C, 8'h80);
        check("ocf_cleared", 32'(irq_ocf), 32'h0);
        rd_reg("tcsr_after_ocf", 5'h08, 8'h08);

        // Input capture at FRC=0x1234 on a rising P2.0 edge
        do_reset();
        wr_reg(5'h08, 8'h12);
        idle(16'h1233);
        port_in[8] = 1'b1;
        idle(1);
        check("icf_set", 32'(irq_icf), 32'h1);
        rd_reg("tcsr_icf", 5'h08, 8'h92);
        rd_reg("icrh", 5'h0D, 8'h12);
        check("icf_cleared", 32'(irq_icf), 32'h0);
        rd_reg("icrl", 5'h0E, 8'h34);
        rd_reg("tcsr_after_icf", 5'h08, 8'h12);
        port_in[8] = 1'b0;
        idle(1);
        rd_reg("tcsr_fall", 5'h08, 8'h12);
        rd_reg("icrh_fall", 5'h0D, 8'h12);
        rd_reg("icrl_fall", 5'h0E, 8'h34);

        // Capture and armed ICRH read on the same cen: set wins, arm dropped
        port_in[8] = 1'b1;
        idle(1);
        port_in[8] = 1'b0;
        idle(1);
        rd_reg("tcsr_arm", 5'h08, 8'h92);
        port_in[8] = 1'b1;
        rd_reg("icrh_same", 5'h0D, 8'h12);
        check("icf_set_wins", 32'(irq_icf), 32'h1);
        rd_reg("icrh_unarmed", 5'h0D, 8'h12);
        check("icf_arm_lost", 32'(irq_icf), 32'h1);
        rd_reg("icrl_new", 5'h0E, 8'h40);
        rd_reg("tcsr_still_icf", 5'h08, 8'h92);
        port_in[8] = 1'b0;

        // Compare level onto P2 bit 1
        do_reset();
        wr_reg(5'h01, 8'h02);
        wr_reg(5'h03, 8'h00);
        wr_reg(5'h08, 8'h01);
        wr_reg(5'h0B, 8'h00);
        wr_reg(5'h0C, 8'h10);
        idle(10);
        check("ocpin_before", 32'(port_out[9]), 32'h0);
        idle(1);
`ifdef JTFRAME_6801_OCPIN_EN
        check("ocpin_match", 32'(port_out[9]), 32'h1);
        rd_reg("p2_read_ocpin", 5'h03, 8'hF2);
`else
        check("ocpin_match", 32'(port_out[9]), 32'h0);
        rd_reg("p2_read_ocpin", 5'h03, 8'hF0);
`endif
        wr_reg(5'h03, 8'h00);
        check("ocpin_cpu_wr", 32'(port_out[9]), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
